// File: rtl/cache_bus_pkg.sv
// ---------------------------------------------------------------------------
// cache_bus_pkg
// Shared definitions for the cache <-> responder bus. The cache side imports
// this package too, so the transfer-type encodings live here only once.
//   xfer_type_e  : rd_type / wr_type encodings (unlisted codes act as word)
//   LINE_BEATS   : 32-bit words per cache line
//   WORD_BYTES   : bytes per word (one strobe bit each)
//   resp_state_e : responder FSM states
// ---------------------------------------------------------------------------
package cache_bus_pkg;

   typedef enum logic [2:0] {
      XFER_BYTE = 3'b000,
      XFER_HALF = 3'b001,
      XFER_WORD = 3'b010,
      XFER_LINE = 3'b100
   } xfer_type_e;

   localparam int LINE_BEATS = 4;
   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_BURST = 2'd2
   } resp_state_e;

   // Only the line code changes behaviour; byte/half/word and every other
   // code are serviced as a full-word access.
   function automatic logic is_line(input logic [2:0] xfer_type);
      return xfer_type == XFER_LINE;
   endfunction

endpackage

// File: rtl/cache_bus_responder_if.sv
// ---------------------------------------------------------------------------
// cache_bus_responder_if
// Read/write request and read-return signals between the cache and the
// responder.
//   master modport : the cache (drives requests, sees rdy/return)
//   slave modport  : the responder
// Read : rd_req, rd_type[2:0], rd_addr[31:0] -> rd_rdy
// Ret  : ret_valid, ret_last, ret_data[31:0]
// Write: wr_req, wr_type[2:0], wr_addr[31:0], wr_wstrb[3:0],
//        wr_data[127:0] -> wr_rdy
// ---------------------------------------------------------------------------
interface cache_bus_responder_if;

   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;

   modport master (
      output rd_req, rd_type, rd_addr,
      input  rd_rdy, ret_valid, ret_last, ret_data,
      output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  wr_rdy
   );

   modport slave (
      input  rd_req, rd_type, rd_addr,
      output rd_rdy, ret_valid, ret_last, ret_data,
      input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output wr_rdy
   );

endinterface

// File: rtl/cache_bus_responder_resp_mem.sv
// ---------------------------------------------------------------------------
// resp_mem
// Backing store for the responder: 2**MEM_AW words split into four banks by
// word-address bits [1:0], so a whole line can be written in one cycle.
// Each bank has one byte-strobed write port; there is one combinational
// read port. Contents are never reset.
//   clock          : write clock
//   wr_en          : perform a write this edge
//   wr_line        : write all four banks with wr_data words 0..3
//   wr_word        : word index of the write (bank = [1:0])
//   wr_strb        : byte enables for single-word writes
//   wr_data[127:0] : line data; single-word writes use bits [31:0]
//   rd_word        : word index to read
//   rd_data        : combinational read data
// ---------------------------------------------------------------------------
module resp_mem
   import cache_bus_pkg::*;
#(
   parameter int MEM_AW = 12
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic              wr_line,
   input  logic [MEM_AW-1:0] wr_word,
   input  logic [3:0]        wr_strb,
   input  logic [127:0]      wr_data,
   input  logic [MEM_AW-1:0] rd_word,
   output logic [31:0]       rd_data
);

   localparam int ROWS = 1 << (MEM_AW - 2);

   logic [MEM_AW-3:0] wr_row;
   logic [MEM_AW-3:0] rd_row;
   logic [31:0]       bank_rd [LINE_BEATS];

   assign wr_row = wr_word[MEM_AW-1:2];
   assign rd_row = rd_word[MEM_AW-1:2];

   for (genvar b = 0; b < LINE_BEATS; b++) begin : g_bank
      logic [31:0] mem [ROWS];
      logic        bank_sel;
      logic [3:0]  strb;
      logic [31:0] wdata;

      // A line write hits every bank with all bytes enabled; a single-word
      // write only hits the bank selected by the low word-address bits.
      assign bank_sel = wr_en && (wr_line || (wr_word[1:0] == 2'(b)));
      assign strb     = wr_line ? 4'hF : wr_strb;
      assign wdata    = wr_line ? wr_data[32*b +: 32] : wr_data[31:0];

      // Byte-strobed write port for this bank.
      always_ff @(posedge clock) begin
         if (bank_sel) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
               if (strb[i]) begin
                  mem[wr_row][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end
      end

      assign bank_rd[b] = mem[rd_row];
   end

   assign rd_data = bank_rd[rd_word[1:0]];

endmodule

// File: rtl/cache_bus_responder.sv
// ---------------------------------------------------------------------------
// cache_bus_responder
// Memory-side responder for a cache. Writes complete in their acceptance
// cycle; reads return after RD_LATENCY cycles as one beat (byte/half/word)
// or four beats (line, words 0..3 of the aligned line).
//   clock  : single rising-edge clock
//   reset  : asynchronous, active-high; drops any in-flight read
//   bus    : cache_bus_responder_if.slave (request, return, rdy signals)
// Parameters: MEM_AW (log2 words held, 4..20), RD_LATENCY (1..15).
// Optional build macro CACHE_BUS_RESPONDER_STALL_INJECT_EN: an 8-bit LFSR
// (x^8+x^6+x^5+x^4+1, seed 8'hA5) injects stalls that hold off rd_rdy and
// wr_rdy. Without it the responder never stalls.
// ---------------------------------------------------------------------------
module cache_bus_responder
   import cache_bus_pkg::*;
#(
   parameter int MEM_AW     = 12,
   parameter int RD_LATENCY = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   cache_bus_responder_if.slave   bus
);

   resp_state_e       state, state_nxt;
   logic [3:0]        lat_cnt, lat_cnt_nxt;
   logic [1:0]        beat_q, beat_nxt;
   logic [MEM_AW-1:0] rd_word_q;
   logic              rd_line_q;
   logic              ret_valid_q, ret_valid_nxt;
   logic              ret_last_q, ret_last_nxt;
   logic [31:0]       ret_data_q, ret_data_nxt;
   logic              stall;
   logic              idle;
   logic              rd_fire;
   logic              wr_fire;
   logic [MEM_AW-1:0] mem_rd_word;
   logic [31:0]       mem_rd_data;
   logic              unused_addr_bits;

`ifdef CACHE_BUS_RESPONDER_STALL_INJECT_EN
   logic [7:0] lfsr;

   // Free-running stall generator; advances every cycle regardless of
   // traffic so its pattern is predictable from reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // Handshakes are gated by reset so they read 0 while reset is held.
   // A write beats a simultaneous read, which stays pending to the next
   // cycle and therefore sees the new data.
   assign idle       = (state == IDLE) && !reset;
   assign bus.wr_rdy = idle && !stall;
   assign bus.rd_rdy = idle && !stall && !bus.wr_req;
   assign wr_fire    = bus.wr_rdy && bus.wr_req;
   assign rd_fire    = bus.rd_rdy && bus.rd_req;

   // Line reads walk the four words of the aligned line; single reads
   // always use the latched word index.
   assign mem_rd_word = rd_line_q ? {rd_word_q[MEM_AW-1:2], beat_q} : rd_word_q;

   resp_mem #(
      .MEM_AW (MEM_AW)
   ) u_mem (
      .clock   (clock),
      .wr_en   (wr_fire),
      .wr_line (is_line(bus.wr_type)),
      .wr_word (bus.wr_addr[MEM_AW+1:2]),
      .wr_strb (bus.wr_wstrb),
      .wr_data (bus.wr_data),
      .rd_word (mem_rd_word),
      .rd_data (mem_rd_data)
   );

   // Next-state and next-output logic. The return registers are loaded on
   // the edge that leaves RD_WAIT and on each RD_BURST edge until the beat
   // marked last has been shown, then the FSM falls back to IDLE.
   always_comb begin
      state_nxt     = state;
      lat_cnt_nxt   = lat_cnt;
      beat_nxt      = beat_q;
      ret_valid_nxt = 1'b0;
      ret_last_nxt  = 1'b0;
      ret_data_nxt  = '0;
      unique case (state)
         IDLE: begin
            if (rd_fire) begin
               state_nxt   = RD_WAIT;
               lat_cnt_nxt = 4'(RD_LATENCY - 1);
               beat_nxt    = 2'd0;
            end
         end
         RD_WAIT: begin
            if (lat_cnt == 4'd0) begin
               state_nxt     = RD_BURST;
               ret_valid_nxt = 1'b1;
               ret_data_nxt  = mem_rd_data;
               ret_last_nxt  = !rd_line_q || (beat_q == 2'd3);
               beat_nxt      = beat_q + 2'd1;
            end else begin
               lat_cnt_nxt = lat_cnt - 4'd1;
            end
         end
         RD_BURST: begin
            if (ret_last_q) begin
               state_nxt = IDLE;
            end else begin
               ret_valid_nxt = 1'b1;
               ret_data_nxt  = mem_rd_data;
               ret_last_nxt  = !rd_line_q || (beat_q == 2'd3);
               beat_nxt      = beat_q + 2'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and registered return outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         beat_q      <= '0;
         ret_valid_q <= 1'b0;
         ret_last_q  <= 1'b0;
         ret_data_q  <= '0;
      end else begin
         state       <= state_nxt;
         lat_cnt     <= lat_cnt_nxt;
         beat_q      <= beat_nxt;
         ret_valid_q <= ret_valid_nxt;
         ret_last_q  <= ret_last_nxt;
         ret_data_q  <= ret_data_nxt;
      end
   end

   // Read request capture; only the in-range word index is kept, which
   // gives the wrap-around aliasing of high address bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_word_q <= '0;
         rd_line_q <= 1'b0;
      end else if (rd_fire) begin
         rd_word_q <= bus.rd_addr[MEM_AW+1:2];
         rd_line_q <= is_line(bus.rd_type);
      end
   end

   assign bus.ret_valid = ret_valid_q;
   assign bus.ret_last  = ret_last_q;
   assign bus.ret_data  = ret_data_q;

   assign unused_addr_bits = ^{bus.rd_addr[31:MEM_AW+2], bus.rd_addr[1:0],
                               bus.wr_addr[31:MEM_AW+2], bus.wr_addr[1:0]};

endmodule

// File: tb/tb_cache_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_cache_bus_responder
// Random and directed traffic against cache_bus_responder. A word-array
// reference model predicts every return beat (data, last flag and arrival
// cycle); expected beats are queued at read acceptance and a separate
// monitor pops and compares them whenever ret_valid is seen.
// With CACHE_BUS_RESPONDER_STALL_INJECT_EN defined the expected rd_rdy /
// wr_rdy pattern follows a reference LFSR sequence.
// ---------------------------------------------------------------------------
module tb_cache_bus_responder;
   import cache_bus_pkg::*;

   localparam int MEM_AW     = 12;
   localparam int RD_LATENCY = 2;
   localparam int WORDS      = 1 << MEM_AW;
   localparam int MASK       = WORDS - 1;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          due;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   beat_t       exp_q[$];
   beat_t       mon_beat;
   logic [31:0] override_q[$];
   bit   [31:0] ref_mem [WORDS];
   logic        stall_m;

   cache_bus_responder_if bus ();

   cache_bus_responder #(
      .MEM_AW     (MEM_AW),
      .RD_LATENCY (RD_LATENCY)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Count rising edges so beat arrival times can be predicted.
   always @(posedge clock) cyc <= cyc + 1;

`ifdef CACHE_BUS_RESPONDER_STALL_INJECT_EN
   logic [7:0] lfsr_m;

   // Reference stall source: taps of x^8+x^6+x^5+x^4+1 as a mask.
   always @(posedge clock or posedge reset) begin
      if (reset) lfsr_m <= 8'hA5;
      else       lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'b1011_1000)};
   end
   assign stall_m = lfsr_m[0];
`else
   assign stall_m = 1'b0;
`endif

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: every valid beat must match the head of the scoreboard;
   // idle cycles must show zero data and no last flag.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.ret_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_output("spurious_ret_valid", {31'b0, bus.ret_valid}, 32'd0);
            end else begin
               mon_beat = exp_q.pop_front();
               check_output("ret_data", bus.ret_data, mon_beat.data);
               check_output("ret_last", {31'b0, bus.ret_last}, {31'b0, mon_beat.last});
               check_output("ret_cycle", cyc, mon_beat.due);
            end
         end else begin
            check_output("idle_ret_data", bus.ret_data, 32'd0);
            check_output("idle_ret_last", {31'b0, bus.ret_last}, 32'd0);
         end
      end
   end

   function automatic bit line_type(input logic [2:0] typ);
      return typ == 3'b100;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [2:0] typ,
                              input logic [3:0] strb, input logic [127:0] data);
      int idx;
      idx = int'(addr >> 2) & MASK;
      if (line_type(typ)) begin
         for (int k = 0; k < 4; k++) ref_mem[(idx & ~3) + k] = data[32*k +: 32];
      end else begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   // Queue the expected beats of a read accepted at the next rising edge.
   task automatic push_read(input logic [31:0] addr, input logic [2:0] typ, input int now);
      int    idx;
      int    n;
      beat_t e;
      idx = int'(addr >> 2) & MASK;
      n   = line_type(typ) ? 4 : 1;
      for (int k = 0; k < n; k++) begin
         e.data = line_type(typ) ? ref_mem[(idx & ~3) + k] : ref_mem[idx];
         if (override_q.size() != 0) e.data = override_q.pop_front();
         e.last = (k == n - 1);
         e.due  = now + 1 + RD_LATENCY + k;
         exp_q.push_back(e);
      end
   endtask

   // Issue a write and/or read, checking the rdy pattern each cycle while
   // waiting; optionally wait for the read to drain.
   task automatic apply_stimulus(input bit do_wr, input logic [31:0] waddr,
                                 input logic [2:0] wtyp, input logic [3:0] strb,
                                 input logic [127:0] wdata, input bit do_rd,
                                 input logic [31:0] raddr, input logic [2:0] rtyp,
                                 input bit wait_done);
      bit acc_w;
      bit acc_r;
      acc_w = !do_wr;
      acc_r = !do_rd;
      @(posedge clock); #1;
      bus.wr_req = do_wr; bus.wr_addr = waddr; bus.wr_type = wtyp;
      bus.wr_wstrb = strb; bus.wr_data = wdata;
      bus.rd_req = do_rd; bus.rd_addr = raddr; bus.rd_type = rtyp;
      for (int n = 0; n < 200 && !(acc_w && acc_r); n++) begin
         @(negedge clock);
         check_output("wr_rdy", {31'b0, bus.wr_rdy}, {31'b0, !stall_m});
         check_output("rd_rdy", {31'b0, bus.rd_rdy}, {31'b0, !stall_m && !bus.wr_req});
         if (bus.wr_req && bus.wr_rdy) begin
            model_write(waddr, wtyp, strb, wdata);
            acc_w = 1'b1;
         end else if (bus.rd_req && bus.rd_rdy) begin
            push_read(raddr, rtyp, cyc);
            acc_r = 1'b1;
         end
         @(posedge clock); #1;
         if (acc_w) bus.wr_req = 1'b0;
         if (acc_r) bus.rd_req = 1'b0;
      end
      check_output("handshake_timeout", {31'b0, acc_w && acc_r}, 32'd1);
      if (do_rd && wait_done) begin
         for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clock);
         check_output("read_drain_timeout", exp_q.size(), 32'd0);
         @(negedge clock);
         check_output("rd_rdy_after_last", {31'b0, bus.rd_rdy}, {31'b0, !stall_m});
      end
   endtask

   task automatic check_reset_outputs();
      check_output("rst_rd_rdy", {31'b0, bus.rd_rdy}, 32'd0);
      check_output("rst_wr_rdy", {31'b0, bus.wr_rdy}, 32'd0);
      check_output("rst_ret_valid", {31'b0, bus.ret_valid}, 32'd0);
      check_output("rst_ret_last", {31'b0, bus.ret_last}, 32'd0);
      check_output("rst_ret_data", bus.ret_data, 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_output("post_rst_rd_rdy", {31'b0, bus.rd_rdy}, {31'b0, !stall_m});
      check_output("post_rst_wr_rdy", {31'b0, bus.wr_rdy}, {31'b0, !stall_m});
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout expected=done");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [127:0] d;
      int op;

      bus.rd_req = 1'b0; bus.rd_type = 3'b0; bus.rd_addr = '0;
      bus.wr_req = 1'b0; bus.wr_type = 3'b0; bus.wr_addr = '0;
      bus.wr_wstrb = '0; bus.wr_data = '0;

      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs();
      release_reset();

      // Single word write then word read.
      apply_stimulus(1, 32'h1000, 3'b010, 4'hF, {96'b0, 32'hDEADBEEF}, 0, 0, 0, 0);
      override_q = '{32'hDEADBEEF};
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'h1000, 3'b010, 1);

      // Line write, then a line read from inside the same line.
      apply_stimulus(1, 32'h2000, 3'b100, 4'h0,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 0, 0, 0, 0);
      override_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'h2008, 3'b100, 1);

      // Partial strobe over a zeroed word; byte read returns the full word.
      apply_stimulus(1, 32'h3000, 3'b010, 4'hF, 128'd0, 0, 0, 0, 0);
      apply_stimulus(1, 32'h3000, 3'b010, 4'b0101, {96'b0, 32'hAABBCCDD}, 0, 0, 0, 0);
      override_q = '{32'h00BB00DD};
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'h3000, 3'b000, 1);

      // Simultaneous read and write at one address: write first, read sees it.
      override_q = '{32'h5A5AC3C3};
      apply_stimulus(1, 32'h1000, 3'b010, 4'hF, {96'b0, 32'h5A5AC3C3},
                     1, 32'h1000, 3'b010, 1);

      // Aliased address (high bits set) reads the same word.
      override_q = '{32'h5A5AC3C3};
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_1000, 3'b001, 1);

      // Initialise a small window, then random traffic with aliasing.
      for (int l = 0; l < 16; l++)
         apply_stimulus(1, 32'(l * 16), 3'b100, 4'h0,
                        {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 2);
         a  = ($urandom & 32'hFFFF_C000) | ($urandom & 32'h0000_00FF);
         b  = ($urandom & 32'hFFFF_C000) | ($urandom & 32'h0000_00FF);
         d  = {$urandom, $urandom, $urandom, $urandom};
         apply_stimulus(op != 1, a, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), d,
                        op != 0, b, 3'($urandom_range(0, 7)), 1);
      end

      // Reset in the middle of a line burst, at beat 2.
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'h2000, 3'b100, 0);
      for (int n = 0; n < 50 && exp_q.size() > 2; n++) @(posedge clock);
      #1;
      check_output("beat2_visible", {31'b0, bus.ret_valid}, 32'd1);
      reset = 1'b1;
      #1;
      exp_q.delete();
      check_reset_outputs();
      repeat (2) @(posedge clock);
      release_reset();
      repeat (10) @(posedge clock);

      // Memory contents survive reset.
      override_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'h2000, 3'b100, 1);
      override_q = '{32'h00BB00DD};
      apply_stimulus(0, 0, 0, 0, 0, 1, 32'h3000, 3'b010, 1);

      repeat (5) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
